instr_fetch: RTL and testbench

Instruction fetch stage for the RISC-V core. It owns the program counter, fetches one 32-bit word at a time from instruction memory through a request/grant/response handshake, and presents the fetched instruction to the decode/control stage, which consumes `inst[6:0]` as its opcode. A taken branch or jump is reported back as a redirect, which kills any in-flight or held fetch.

---
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory and decode-side signal bundle for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready, redirect, redirect_pc,
        output misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready, redirect, redirect_pc,
        input  misalign_err
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : RISC-V fetch stage: owns the PC, one outstanding imem request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire              clk,
    input  wire              rst_n,
    instr_fetch_if.master    bus
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_misalign_err;

    logic [31:0] w_redir_pc;
    logic        w_redir_mis;

    assign w_redir_pc  = {bus.redirect_pc[31:2], 2'b00};
    assign w_redir_mis = |bus.redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_inst         <= C_NOP;
            r_inst_pc      <= RESET_PC;
            r_misalign_err <= 1'b0;
        end else begin
            // Redirect is honoured in every state except BOOT.
            if (bus.redirect && (r_state != S_BOOT)) begin
                r_pc <= w_redir_pc;
                if (w_redir_mis) begin
                    r_misalign_err <= 1'b1;
                end
            end

            case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // A granted request that is redirected still returns data, which must be dropped.
                    if (bus.imem_gnt) begin
                        r_state <= bus.redirect ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.redirect) begin
                            r_state <= S_REQ;
                        end else begin
                            r_inst    <= bus.imem_rdata;
                            r_inst_pc <= r_pc;
                            r_pc      <= r_pc + 32'd4;
                            r_state   <= S_HOLD;
                        end
                    end else if (bus.redirect) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect || bus.inst_ready) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_req     = (r_state == S_REQ);
    assign bus.imem_addr    = r_pc;
    assign bus.inst_valid   = (r_state == S_HOLD);
    assign bus.inst         = r_inst;
    assign bus.inst_pc      = r_inst_pc;
    assign bus.misalign_err = r_misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (32'h0000_0100)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs set after this return are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        repeat (2) step();
        chk_eq("rst_req",   {31'b0, bus.imem_req},     32'h0);
        chk_eq("rst_addr",  bus.imem_addr,             32'h100);
        chk_eq("rst_valid", {31'b0, bus.inst_valid},   32'h0);
        chk_eq("rst_inst",  bus.inst,                  32'h13);
        chk_eq("rst_ipc",   bus.inst_pc,               32'h100);
        chk_eq("rst_mis",   {31'b0, bus.misalign_err}, 32'h0);

        // Boot and first zero-wait fetch
        rst_n = 1'b1;
        step();
        chk_eq("boot_req",  {31'b0, bus.imem_req}, 32'h1);
        chk_eq("boot_addr", bus.imem_addr,         32'h100);
        bus.imem_gnt = 1'b1;
        step();
        chk_eq("wait_req",  {31'b0, bus.imem_req}, 32'h0);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0050_0093;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("f1_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk_eq("f1_inst",  bus.inst,                32'h0050_0093);
        chk_eq("f1_ipc",   bus.inst_pc,             32'h100);
        chk_eq("f1_addr",  bus.imem_addr,           32'h104);

        // Backpressure in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            chk_eq("bp_valid", {31'b0, bus.inst_valid}, 32'h1);
            chk_eq("bp_inst",  bus.inst,                32'h0050_0093);
            chk_eq("bp_ipc",   bus.inst_pc,             32'h100);
            chk_eq("bp_req",   {31'b0, bus.imem_req},   32'h0);
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk_eq("bp_rel_req",   {31'b0, bus.imem_req},   32'h1);
        chk_eq("bp_rel_addr",  bus.imem_addr,           32'h104);
        chk_eq("bp_rel_valid", {31'b0, bus.inst_valid}, 32'h0);

        // Second fetch, then redirect in HOLD together with inst_ready
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00A0_0113;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("f2_inst", bus.inst,      32'h00A0_0113);
        chk_eq("f2_ipc",  bus.inst_pc,   32'h104);
        chk_eq("f2_addr", bus.imem_addr, 32'h108);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.inst_ready  = 1'b1;
        step();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        chk_eq("rh_valid", {31'b0, bus.inst_valid},   32'h0);
        chk_eq("rh_req",   {31'b0, bus.imem_req},     32'h1);
        chk_eq("rh_addr",  bus.imem_addr,             32'h200);
        chk_eq("rh_mis",   {31'b0, bus.misalign_err}, 32'h0);

        // Redirect while waiting for a slow response
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        step();
        chk_eq("rw_req", {31'b0, bus.imem_req}, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        chk_eq("rw_drop_req",  {31'b0, bus.imem_req}, 32'h0);
        chk_eq("rw_drop_addr", bus.imem_addr,         32'h40);
        step();
        chk_eq("rw_drop2_req", {31'b0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("rw_req2",  {31'b0, bus.imem_req},   32'h1);
        chk_eq("rw_addr2", bus.imem_addr,           32'h40);
        chk_eq("rw_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk_eq("rw_inst",  bus.inst,                32'h00A0_0113);

        // Misaligned redirect while ungranted in REQ
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h46;
        step();
        bus.redirect = 1'b0;
        chk_eq("mis_addr", bus.imem_addr,             32'h44);
        chk_eq("mis_flag", {31'b0, bus.misalign_err}, 32'h1);
        chk_eq("mis_req",  {31'b0, bus.imem_req},     32'h1);

        // Granted request redirected in REQ must drain through DROP
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        step();
        bus.imem_gnt = 1'b0;
        bus.redirect = 1'b0;
        chk_eq("rg_req",  {31'b0, bus.imem_req}, 32'h0);
        chk_eq("rg_addr", bus.imem_addr,         32'h80);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("rg_req2",  {31'b0, bus.imem_req},   32'h1);
        chk_eq("rg_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk_eq("rg_inst",  bus.inst,                32'h00A0_0113);

        // PC wrap at the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        chk_eq("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5037;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("wr_inst", bus.inst,                  32'h1234_5037);
        chk_eq("wr_ipc",  bus.inst_pc,               32'hFFFF_FFFC);
        chk_eq("wr_next", bus.imem_addr,             32'h0);
        chk_eq("wr_mis",  {31'b0, bus.misalign_err}, 32'h1);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk_eq("wr_req", {31'b0, bus.imem_req}, 32'h1);

        // Stray rvalid in REQ is ignored
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2222_2222;
        step();
        bus.imem_rvalid = 1'b0;
        chk_eq("pv_req",  {31'b0, bus.imem_req}, 32'h1);
        chk_eq("pv_addr", bus.imem_addr,         32'h0);
        chk_eq("pv_inst", bus.inst,              32'h1234_5037);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk_eq("ar_req",  {31'b0, bus.imem_req},     32'h0);
        chk_eq("ar_addr", bus.imem_addr,             32'h100);
        chk_eq("ar_inst", bus.inst,                  32'h13);
        chk_eq("ar_mis",  {31'b0, bus.misalign_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
